// File: rtl/pri_arbiter_ctrl.sv
// Registered single-owner arbiter with hold-while-requesting and optional hold limit.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise the highest index wins.
module pri_arbiter_ctrl #(
    parameter int unsigned N        = 8,
    parameter int unsigned IDW      = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    localparam int unsigned HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic           timeout_q, timeout_d;

    logic [IDW-1:0] win_id;
    logic           owner_req;
    logic           hold_limit;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    // Ascending search from rr_ptr with wrap; the lowest offset that is set wins.
    always_comb begin
        int idx;
        idx    = 0;
        win_id = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % int'(N);
            if (req[idx]) win_id = IDW'(idx);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && (|req)) rr_ptr_d = IDW'((int'(win_id) + 1) % int'(N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    // Fixed priority: the highest set index wins.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i]) win_id = IDW'(i);
        end
    end
`endif

    assign owner_req  = req[gnt_id_q];
    assign hold_limit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = GRANT;
            GRANT:   if (!owner_req || hold_limit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and hold-counter logic; a release always clears the grant for one idle cycle.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d       = N'(1) << win_id;
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end else begin
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (!owner_req || hold_limit) begin
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    timeout_d   = owner_req;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pri_arbiter_ctrl.sv
// Self-checking bench for pri_arbiter_ctrl (MAX_HOLD=4): vector table, reset corner
// cases and random requests against a cycle-level ownership model.
module tb_pri_arbiter_ctrl;

    localparam int N    = 8;
    localparam int MAXH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    pri_arbiter_ctrl #(.N(8), .IDW(3), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: who owns the resource and for how many cycles so far.
    int m_owner;
    int m_cycles;
    int m_ptr;
    bit m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [7:0] r, input logic [7:0] g, input logic [2:0] id,
                       input logic v, input logic t);
        vec_t e;
        e.req = r; e.gnt = g; e.id = id; e.valid = v; e.to = t;
        tbl.push_back(e);
    endtask

    function automatic int pick(input logic [7:0] r);
        int w;
        bit found;
        w = 0;
        found = 0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            if (!found && r[(m_ptr + k) % N]) begin
                w = (m_ptr + k) % N;
                found = 1;
            end
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (!found && r[i]) begin
                w = i;
                found = 1;
            end
        end
`endif
        return w;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_cycles = 0; m_ptr = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        int w;
        m_to = 0;
        if (m_owner < 0) begin
            if (r != 8'h00) begin
                w        = pick(r);
                m_owner  = w;
                m_cycles = 1;
                m_ptr    = (w + 1) % N;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (m_cycles == MAXH) begin
            m_owner = -1;
            m_to    = 1;
        end else begin
            m_cycles++;
        end
    endtask

    // Apply req for one edge, advance the model, sample on the falling edge.
    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
    endtask

    task automatic cmp_model(input string tag);
        logic [7:0] eg;
        logic [2:0] eid;
        eg  = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        eid = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        chk({tag, ".gnt"},     32'(gnt),       32'(eg));
        chk({tag, ".gnt_id"},  32'(gnt_id),    32'(eid));
        chk({tag, ".valid"},   32'(gnt_valid), 32'(m_owner >= 0));
        chk({tag, ".timeout"}, 32'(timeout),   32'(m_to));
        chk({tag, ".onehot"},  32'(gnt),       gnt_valid ? 32'(8'h01 << gnt_id) : 32'd0);
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] prev;

        // Asynchronous reset seen before any clock edge, with every request high.
        rst_n = 1'b0;
        req   = 8'hFF;
        model_reset();
        #1;
        chk("rst.gnt",     32'(gnt),       32'd0);
        chk("rst.gnt_id",  32'(gnt_id),    32'd0);
        chk("rst.valid",   32'(gnt_valid), 32'd0);
        chk("rst.timeout", 32'(timeout),   32'd0);
        #6;
        req   = 8'h00;
        rst_n = 1'b1;
        @(negedge clk);

`ifdef ARB_ROUND_ROBIN_EN
        // All requesting: each owner held MAX_HOLD cycles, then a timeout idle cycle, rotating 0,1,2.
        for (int k = 0; k < 15; k++) begin
            if (k % 5 < 4) add(8'hFF, 8'h01 << (k / 5), 3'(k / 5), 1'b1, 1'b0);
            else           add(8'hFF, 8'h00, 3'd0, 1'b0, 1'b1);
        end
`else
        add(8'h24, 8'h20, 3'd5, 1'b1, 1'b0);
        add(8'hA4, 8'h20, 3'd5, 1'b1, 1'b0);
        add(8'h24, 8'h20, 3'd5, 1'b1, 1'b0);
        add(8'h04, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h84, 8'h80, 3'd7, 1'b1, 1'b0);
        add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        add(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        add(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        add(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        add(8'h04, 8'h00, 3'd0, 1'b0, 1'b1);
        add(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        add(8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        add(8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        add(8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
`endif
        foreach (tbl[i]) begin
            step(tbl[i].req);
            chk($sformatf("vec%0d.gnt", i),     32'(gnt),       32'(tbl[i].gnt));
            chk($sformatf("vec%0d.gnt_id", i),  32'(gnt_id),    32'(tbl[i].id));
            chk($sformatf("vec%0d.valid", i),   32'(gnt_valid), 32'(tbl[i].valid));
            chk($sformatf("vec%0d.timeout", i), 32'(timeout),   32'(tbl[i].to));
        end

        // Reset pulsed mid-grant of requester 3 clears outputs without a clock edge.
        step(8'h08);
        chk("pre_rst.gnt_id", 32'(gnt_id), 32'd3);
        step(8'h08);
        chk("pre_rst.hold", 32'(gnt), 32'h08);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.gnt",   32'(gnt),       32'd0);
        chk("midrst.valid", 32'(gnt_valid), 32'd0);
        chk("midrst.id",    32'(gnt_id),    32'd0);
        model_reset();
        req = 8'h00;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        step(8'hFF);
`ifdef ARB_ROUND_ROBIN_EN
        chk("post_rst.gnt_id", 32'(gnt_id), 32'd0);
`else
        chk("post_rst.gnt_id", 32'(gnt_id), 32'd7);
`endif
        cmp_model("post_rst");

        // Random requests: sparse, empty, or repeated vectors to reach the hold limit.
        prev = 8'h00;
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 5))
                0:       r = 8'h00;
                1, 2:    r = prev;
                3:       r = 8'($urandom) & 8'($urandom);
                default: r = 8'($urandom);
            endcase
            prev = r;
            step(r);
            cmp_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
